// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and line-state monitor definitions used by the device core.
// Default timing constants assume a 60 MHz UTMI clock.
package usb_utmi_pkg;

   typedef enum logic [1:0] {
      UTM_LS_SE0 = 2'b00,
      UTM_LS_J   = 2'b01,
      UTM_LS_K   = 2'b10,
      UTM_LS_SE1 = 2'b11
   } utmi_line_state_t;

   typedef enum logic [1:0] {
      UTM_OM_NORMAL  = 2'b00,
      UTM_OM_NODRIVE = 2'b01,
      UTM_OM_DISABLE = 2'b10,
      UTM_OM_RSVD    = 2'b11
   } utmi_op_mode_t;

   // ST_RWAKE keeps its encoding even when remote wakeup is not built.
   typedef enum logic [2:0] {
      ST_ACTIVE    = 3'd0,
      ST_BUS_RESET = 3'd1,
      ST_SUSPEND   = 3'd2,
      ST_RESUME    = 3'd3,
      ST_RWAKE     = 3'd4
   } usb_lsmon_state_t;

   localparam int unsigned UTM_T_RESET       = 150;
   localparam int unsigned UTM_T_SUSPEND     = 180000;
   localparam int unsigned UTM_T_RESUME      = 60;
   localparam int unsigned UTM_T_RWAKE_IDLE  = 300000;
   localparam int unsigned UTM_T_RWAKE_DRIVE = 120000;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/usb_utmi_ls_filter.sv
// Debounce filter for UTMI LineState: registers the raw input once and only
// forwards a value after FILT_CYCLES consecutive identical samples.
module usb_utmi_ls_filter
   import usb_utmi_pkg::*;
#(
   parameter int unsigned FILT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  utmi_line_state_t line_state,
   output utmi_line_state_t ls_filt,
   output logic             ls_change
);

   localparam int unsigned   CntW   = cnt_width(FILT_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYCLES - 1);

   utmi_line_state_t  sample_q, sample_d;
   utmi_line_state_t  ls_filt_q, ls_filt_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   // cnt_q == k means the current sample has been seen k+1 times in a row.
   always_comb begin
      sample_d  = line_state;
      cnt_d     = cnt_q;
      ls_filt_d = ls_filt_q;
      if (line_state != sample_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == CntMax) begin
         ls_filt_d = sample_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_q  <= UTM_LS_J;
         cnt_q     <= '0;
         ls_filt_q <= UTM_LS_J;
      end else begin
         sample_q  <= sample_d;
         cnt_q     <= cnt_d;
         ls_filt_q <= ls_filt_d;
      end
   end

   assign ls_filt   = ls_filt_q;
   assign ls_change = (ls_filt_d != ls_filt_q);

endmodule

// File: rtl/usb_utmi_linestate_mon.sv
// UTMI line-state monitor: debounces LineState, times it and tracks bus reset,
// suspend and host resume. Define USB_UTMI_RWAKEUP_EN to add remote wakeup.
module usb_utmi_linestate_mon
   import usb_utmi_pkg::*;
#(
   parameter int unsigned FILT_CYCLES        = 4,
   parameter int unsigned RESET_CYCLES       = UTM_T_RESET,
   parameter int unsigned SUSPEND_CYCLES     = UTM_T_SUSPEND,
   parameter int unsigned RESUME_CYCLES      = UTM_T_RESUME
`ifdef USB_UTMI_RWAKEUP_EN
   ,
   parameter int unsigned RWAKE_IDLE_CYCLES  = UTM_T_RWAKE_IDLE,
   parameter int unsigned RWAKE_DRIVE_CYCLES = UTM_T_RWAKE_DRIVE
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  utmi_line_state_t line_state,
`ifdef USB_UTMI_RWAKEUP_EN
   input  logic             rwakeup_req,
   output utmi_op_mode_t    op_mode,
   output logic             tx_k,
`endif
   output utmi_line_state_t ls_filt,
   output logic             bus_reset,
   output logic             bus_reset_pulse,
   output logic             suspend,
   output logic             resume_pulse,
   output logic             se1_err,
   output usb_lsmon_state_t mon_state
);

   localparam int unsigned     DurW      = cnt_width(SUSPEND_CYCLES);
   localparam logic [DurW-1:0] DurMax    = DurW'(SUSPEND_CYCLES);
   localparam logic [DurW-1:0] HitReset  = DurW'(RESET_CYCLES - 1);
   localparam logic [DurW-1:0] HitSusp   = DurW'(SUSPEND_CYCLES - 1);
   localparam logic [DurW-1:0] HitResume = DurW'(RESUME_CYCLES - 1);

   logic             ls_change;
   usb_lsmon_state_t state_q, state_d;
   logic [DurW-1:0]  dur_q, dur_d;
   logic             bus_reset_q, bus_reset_d;
   logic             bus_reset_pulse_q, bus_reset_pulse_d;
   logic             suspend_q, suspend_d;
   logic             resume_pulse_q, resume_pulse_d;
   logic             se1_err_q, se1_err_d;
   logic             se0_hit, j_hit, k_hit;
   logic             rw_go, rw_done;

   usb_utmi_ls_filter #(
      .FILT_CYCLES(FILT_CYCLES)
   ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .line_state(line_state),
      .ls_filt   (ls_filt),
      .ls_change (ls_change)
   );

`ifdef USB_UTMI_RWAKEUP_EN
   // One counter serves both phases: idle time in suspend, drive time in wakeup.
   localparam int unsigned    RwMax  = max_u(RWAKE_IDLE_CYCLES, RWAKE_DRIVE_CYCLES);
   localparam int unsigned    RwW    = cnt_width(RwMax);
   localparam logic [RwW-1:0] RwSat  = RwW'(RwMax);
   localparam logic [RwW-1:0] RwIdle = RwW'(RWAKE_IDLE_CYCLES);
   localparam logic [RwW-1:0] RwDone = RwW'(RWAKE_DRIVE_CYCLES - 1);

   logic [RwW-1:0] rw_cnt_q, rw_cnt_d;
   utmi_op_mode_t  op_mode_q, op_mode_d;
   logic           tx_k_q, tx_k_d;

   always_comb begin
      rw_go   = (state_q == ST_SUSPEND) && rwakeup_req && (rw_cnt_q >= RwIdle);
      rw_done = (state_q == ST_RWAKE) && (rw_cnt_q == RwDone);
   end

   always_comb begin
      rw_cnt_d = rw_cnt_q;
      if ((state_d != state_q) || !((state_q == ST_SUSPEND) || (state_q == ST_RWAKE))) begin
         rw_cnt_d = '0;
      end else if (rw_cnt_q != RwSat) begin
         rw_cnt_d = rw_cnt_q + 1'b1;
      end
      op_mode_d = (state_d == ST_RWAKE) ? UTM_OM_DISABLE : UTM_OM_NORMAL;
      tx_k_d    = (state_d == ST_RWAKE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rw_cnt_q  <= '0;
         op_mode_q <= UTM_OM_NORMAL;
         tx_k_q    <= 1'b0;
      end else begin
         rw_cnt_q  <= rw_cnt_d;
         op_mode_q <= op_mode_d;
         tx_k_q    <= tx_k_d;
      end
   end

   assign op_mode = op_mode_q;
   assign tx_k    = tx_k_q;
`else
   assign rw_go   = 1'b0;
   assign rw_done = 1'b0;
`endif

   always_comb begin
      dur_d = dur_q;
      if (ls_change) begin
         dur_d = '0;
      end else if (dur_q != DurMax) begin
         dur_d = dur_q + 1'b1;
      end

      // A hit fires in the N-th cycle of the state; the move lands one cycle later.
      se0_hit = (ls_filt == UTM_LS_SE0) && (dur_q == HitReset);
      j_hit   = (ls_filt == UTM_LS_J)   && (dur_q == HitSusp);
      k_hit   = (ls_filt == UTM_LS_K)   && (dur_q == HitResume);

      state_d = state_q;
      case (state_q)
         ST_ACTIVE: begin
            if (se0_hit) begin
               state_d = ST_BUS_RESET;
            end else if (j_hit) begin
               state_d = ST_SUSPEND;
            end
         end
         ST_BUS_RESET: begin
            if (ls_filt != UTM_LS_SE0) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_SUSPEND: begin
            if (se0_hit) begin
               state_d = ST_BUS_RESET;
            end else if (k_hit) begin
               state_d = ST_RESUME;
            end else if (rw_go) begin
               state_d = ST_RWAKE;
            end
         end
         ST_RESUME: begin
            if (ls_filt != UTM_LS_K) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_RWAKE: begin
            if (rw_done) begin
               state_d = ST_RESUME;
            end
         end
         default: state_d = ST_ACTIVE;
      endcase

      bus_reset_d       = (state_d == ST_BUS_RESET);
      bus_reset_pulse_d = (state_d == ST_BUS_RESET) && (state_q != ST_BUS_RESET);
      suspend_d         = (state_d == ST_SUSPEND);
      resume_pulse_d    = (state_q == ST_SUSPEND) && (state_d == ST_RESUME);
      // dur is zero only in the first cycle of a new filtered value.
      se1_err_d         = (ls_filt == UTM_LS_SE1) && (dur_q == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_ACTIVE;
         dur_q             <= '0;
         bus_reset_q       <= 1'b0;
         bus_reset_pulse_q <= 1'b0;
         suspend_q         <= 1'b0;
         resume_pulse_q    <= 1'b0;
         se1_err_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         dur_q             <= dur_d;
         bus_reset_q       <= bus_reset_d;
         bus_reset_pulse_q <= bus_reset_pulse_d;
         suspend_q         <= suspend_d;
         resume_pulse_q    <= resume_pulse_d;
         se1_err_q         <= se1_err_d;
      end
   end

   assign bus_reset       = bus_reset_q;
   assign bus_reset_pulse = bus_reset_pulse_q;
   assign suspend         = suspend_q;
   assign resume_pulse    = resume_pulse_q;
   assign se1_err         = se1_err_q;
   assign mon_state       = state_q;

endmodule

// File: tb/tb_usb_utmi_linestate_mon.sv
// Directed bench for usb_utmi_linestate_mon with short timing parameters.
// The remote wakeup scenario is built only when USB_UTMI_RWAKEUP_EN is defined.
module tb_usb_utmi_linestate_mon;
   import usb_utmi_pkg::*;

   logic             clk;
   logic             rst;
   utmi_line_state_t line_state;
   utmi_line_state_t ls_filt;
   logic             bus_reset;
   logic             bus_reset_pulse;
   logic             suspend;
   logic             resume_pulse;
   logic             se1_err;
   usb_lsmon_state_t mon_state;
`ifdef USB_UTMI_RWAKEUP_EN
   logic             rwakeup_req;
   utmi_op_mode_t    op_mode;
   logic             tx_k;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int cnt_rstp = 0;
   int cnt_resp = 0;
   int cnt_se1  = 0;

   usb_utmi_linestate_mon #(
      .FILT_CYCLES       (2),
      .RESET_CYCLES      (10),
      .SUSPEND_CYCLES    (50),
      .RESUME_CYCLES     (8)
`ifdef USB_UTMI_RWAKEUP_EN
      ,
      .RWAKE_IDLE_CYCLES (20),
      .RWAKE_DRIVE_CYCLES(12)
`endif
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .line_state     (line_state),
`ifdef USB_UTMI_RWAKEUP_EN
      .rwakeup_req    (rwakeup_req),
      .op_mode        (op_mode),
      .tx_k           (tx_k),
`endif
      .ls_filt        (ls_filt),
      .bus_reset      (bus_reset),
      .bus_reset_pulse(bus_reset_pulse),
      .suspend        (suspend),
      .resume_pulse   (resume_pulse),
      .se1_err        (se1_err),
      .mon_state      (mon_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n clocks, sampling 1 time unit after each rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (bus_reset_pulse === 1'b1) cnt_rstp++;
         if (resume_pulse === 1'b1) cnt_resp++;
         if (se1_err === 1'b1) cnt_se1++;
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      line_state = UTM_LS_J;
`ifdef USB_UTMI_RWAKEUP_EN
      rwakeup_req = 1'b0;
`endif
      tick(2);
      rst      = 1'b0;
      cnt_rstp = 0;
      cnt_resp = 0;
      cnt_se1  = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (ls_filt !== UTM_LS_J) $display("FAIL rst_ls_filt: got %0d want %0d", ls_filt, UTM_LS_J);
      else n_pass++;
      n_checks++;
      if (mon_state !== ST_ACTIVE) $display("FAIL rst_state: got %0d want %0d", mon_state, ST_ACTIVE);
      else n_pass++;
      n_checks++;
      if ({bus_reset, suspend, bus_reset_pulse, resume_pulse, se1_err} !== 5'b0)
         $display("FAIL rst_outputs: got %b want 00000",
                  {bus_reset, suspend, bus_reset_pulse, resume_pulse, se1_err});
      else n_pass++;
   endtask

   task automatic test_suspend_bus_reset();
      do_reset();
      tick(49);
      n_checks++;
      if (suspend !== 1'b0) $display("FAIL susp_early: got %b want 0", suspend);
      else n_pass++;
      tick(1);
      n_checks++;
      if (suspend !== 1'b1 || mon_state !== ST_SUSPEND)
         $display("FAIL susp_on: suspend=%b state=%0d want 1/%0d", suspend, mon_state, ST_SUSPEND);
      else n_pass++;
      // SE0 one cycle short of the reset threshold
      line_state = UTM_LS_SE0;
      tick(9);
      line_state = UTM_LS_J;
      tick(15);
      n_checks++;
      if (bus_reset !== 1'b0 || cnt_rstp != 0 || mon_state !== ST_SUSPEND)
         $display("FAIL se0_short: bus_reset=%b pulses=%0d state=%0d want 0/0/%0d",
                  bus_reset, cnt_rstp, mon_state, ST_SUSPEND);
      else n_pass++;
      line_state = UTM_LS_SE0;
      tick(12);
      n_checks++;
      if (bus_reset !== 1'b0) $display("FAIL rst_early: got %b want 0", bus_reset);
      else n_pass++;
      tick(1);
      n_checks++;
      if (bus_reset !== 1'b1 || bus_reset_pulse !== 1'b1 || mon_state !== ST_BUS_RESET)
         $display("FAIL rst_enter: bus_reset=%b pulse=%b state=%0d want 1/1/%0d",
                  bus_reset, bus_reset_pulse, mon_state, ST_BUS_RESET);
      else n_pass++;
      tick(5);
      n_checks++;
      if (cnt_rstp != 1 || bus_reset !== 1'b1)
         $display("FAIL rst_hold: pulses=%0d bus_reset=%b want 1/1", cnt_rstp, bus_reset);
      else n_pass++;
      line_state = UTM_LS_J;
      tick(3);
      n_checks++;
      if (bus_reset !== 1'b1) $display("FAIL rst_exit_early: got %b want 1", bus_reset);
      else n_pass++;
      tick(1);
      n_checks++;
      if (bus_reset !== 1'b0 || mon_state !== ST_ACTIVE)
         $display("FAIL rst_exit: bus_reset=%b state=%0d want 0/%0d", bus_reset, mon_state, ST_ACTIVE);
      else n_pass++;
      // bus reset entered from the active state
      line_state = UTM_LS_SE0;
      tick(13);
      n_checks++;
      if (bus_reset !== 1'b1 || cnt_rstp != 2)
         $display("FAIL rst_from_active: bus_reset=%b pulses=%0d want 1/2", bus_reset, cnt_rstp);
      else n_pass++;
      line_state = UTM_LS_J;
      tick(4);
   endtask

   task automatic test_resume();
      do_reset();
      tick(50);
      line_state = UTM_LS_K;
      tick(8);
      line_state = UTM_LS_J;
      tick(2);
      n_checks++;
      if (suspend !== 1'b1 || resume_pulse !== 1'b0)
         $display("FAIL resume_early: suspend=%b pulse=%b want 1/0", suspend, resume_pulse);
      else n_pass++;
      tick(1);
      n_checks++;
      if (resume_pulse !== 1'b1 || suspend !== 1'b0 || mon_state !== ST_RESUME)
         $display("FAIL resume_enter: pulse=%b suspend=%b state=%0d want 1/0/%0d",
                  resume_pulse, suspend, mon_state, ST_RESUME);
      else n_pass++;
      tick(1);
      n_checks++;
      if (mon_state !== ST_ACTIVE || resume_pulse !== 1'b0 || cnt_resp != 1)
         $display("FAIL resume_exit: state=%0d pulse=%b count=%0d want %0d/0/1",
                  mon_state, resume_pulse, cnt_resp, ST_ACTIVE);
      else n_pass++;
      // K one cycle short
      do_reset();
      tick(50);
      line_state = UTM_LS_K;
      tick(7);
      line_state = UTM_LS_J;
      tick(10);
      n_checks++;
      if (suspend !== 1'b1 || cnt_resp != 0 || mon_state !== ST_SUSPEND)
         $display("FAIL k_short: suspend=%b count=%0d state=%0d want 1/0/%0d",
                  suspend, cnt_resp, mon_state, ST_SUSPEND);
      else n_pass++;
   endtask

   task automatic test_glitch();
      int bad;
      bad = 0;
      do_reset();
      for (int i = 1; i <= 60; i++) begin
         line_state = (i % 5 == 0) ? UTM_LS_SE0 : UTM_LS_J;
         tick(1);
         if (ls_filt !== UTM_LS_J) bad++;
         if (i == 49) begin
            n_checks++;
            if (suspend !== 1'b0) $display("FAIL glitch_susp_early: got %b want 0", suspend);
            else n_pass++;
         end
         if (i == 50) begin
            n_checks++;
            if (suspend !== 1'b1) $display("FAIL glitch_susp_on: got %b want 1", suspend);
            else n_pass++;
         end
      end
      line_state = UTM_LS_J;
      n_checks++;
      if (bad != 0) $display("FAIL glitch_ls_filt: non-J cycles=%0d want 0", bad);
      else n_pass++;
   endtask

   task automatic test_se1();
      do_reset();
      tick(5);
      line_state = UTM_LS_SE1;
      tick(3);
      n_checks++;
      if (ls_filt !== UTM_LS_SE1 || se1_err !== 1'b0)
         $display("FAIL se1_filt: ls_filt=%0d err=%b want %0d/0", ls_filt, se1_err, UTM_LS_SE1);
      else n_pass++;
      tick(1);
      n_checks++;
      if (se1_err !== 1'b1 || mon_state !== ST_ACTIVE)
         $display("FAIL se1_pulse: err=%b state=%0d want 1/%0d", se1_err, mon_state, ST_ACTIVE);
      else n_pass++;
      tick(1);
      line_state = UTM_LS_J;
      tick(52);
      n_checks++;
      if (suspend !== 1'b0 || cnt_se1 != 1)
         $display("FAIL se1_dur: suspend=%b pulses=%0d want 0/1", suspend, cnt_se1);
      else n_pass++;
      tick(1);
      n_checks++;
      if (suspend !== 1'b1) $display("FAIL se1_susp: got %b want 1", suspend);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick(50);
      line_state = UTM_LS_K;
      tick(6);
      rst = 1'b1;
      tick(1);
      n_checks++;
      if (ls_filt !== UTM_LS_J || mon_state !== ST_ACTIVE ||
          {bus_reset, suspend, bus_reset_pulse, resume_pulse, se1_err} !== 5'b0)
         $display("FAIL mid_rst: ls=%0d state=%0d outs=%b want %0d/%0d/00000", ls_filt, mon_state,
                  {bus_reset, suspend, bus_reset_pulse, resume_pulse, se1_err}, UTM_LS_J, ST_ACTIVE);
      else n_pass++;
      rst = 1'b0;
      tick(12);
      n_checks++;
      if (cnt_resp != 0 || mon_state !== ST_ACTIVE)
         $display("FAIL mid_rst_after: resumes=%0d state=%0d want 0/%0d", cnt_resp, mon_state, ST_ACTIVE);
      else n_pass++;
      line_state = UTM_LS_J;
      tick(4);
   endtask

`ifdef USB_UTMI_RWAKEUP_EN
   task automatic test_rwake();
      do_reset();
      tick(50);
      tick(10);
      rwakeup_req = 1'b1;
      tick(1);
      rwakeup_req = 1'b0;
      n_checks++;
      if (mon_state !== ST_SUSPEND || tx_k !== 1'b0)
         $display("FAIL rw_early: state=%0d tx_k=%b want %0d/0", mon_state, tx_k, ST_SUSPEND);
      else n_pass++;
      tick(13);
      n_checks++;
      if (mon_state !== ST_SUSPEND) $display("FAIL rw_latched: state=%0d want %0d", mon_state, ST_SUSPEND);
      else n_pass++;
      tick(1);
      rwakeup_req = 1'b1;
      tick(1);
      rwakeup_req = 1'b0;
      n_checks++;
      if (mon_state !== ST_RWAKE || tx_k !== 1'b1 || op_mode !== UTM_OM_DISABLE)
         $display("FAIL rw_enter: state=%0d tx_k=%b op=%b want %0d/1/10", mon_state, tx_k, op_mode, ST_RWAKE);
      else n_pass++;
      tick(11);
      n_checks++;
      if (tx_k !== 1'b1) $display("FAIL rw_drive: tx_k=%b want 1", tx_k);
      else n_pass++;
      tick(1);
      n_checks++;
      if (tx_k !== 1'b0 || op_mode !== UTM_OM_NORMAL || mon_state !== ST_RESUME)
         $display("FAIL rw_done: tx_k=%b op=%b state=%0d want 0/00/%0d", tx_k, op_mode, mon_state, ST_RESUME);
      else n_pass++;
      tick(3);
   endtask
`endif

   initial begin
      rst        = 1'b1;
      line_state = UTM_LS_J;
`ifdef USB_UTMI_RWAKEUP_EN
      rwakeup_req = 1'b0;
`endif
      test_reset();
      test_suspend_bus_reset();
      test_resume();
      test_glitch();
      test_se1();
      test_reset_mid();
`ifdef USB_UTMI_RWAKEUP_EN
      test_rwake();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
